// File: rtl/and_gate.sv
// Branch-taken AND gate for the PC mux, plus a registered copy of the select
// and saturating statistics counters (branches requested, branches taken).

// Per-counter slice: saturating up-counter with synchronous clear.
module and_gate_satcnt #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat_hit
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic at_max;

    assign at_max    = (o_cnt == CNT_MAX);
    // An increment request while already pinned at max is what marks saturation.
    assign o_sat_hit = i_inc & at_max;

    // Count up on request, hold at max, clear wins over increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_cnt <= '0;
        else if (i_clr)
            o_cnt <= '0;
        else if (i_inc && !at_max)
            o_cnt <= o_cnt + 1'b1;
    end
endmodule

module and_gate #(
    parameter int CNT_W = 16   // legal 2..32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_zero_alu,
    input  logic             i_control_unit,
    input  logic             i_clr,
    output logic             o_mux,
    output logic             o_mux_q,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_taken_cnt,
    output logic             o_cnt_sat
);
    localparam int NUM_CNT = 2;   // [0] branch requests, [1] branches taken
    localparam int STAGES  = 1;

    logic [STAGES:0]                vld_pipe;
    logic [NUM_CNT-1:0]             inc;
    logic [NUM_CNT-1:0]             sat_hit;
    logic [NUM_CNT-1:0][CNT_W-1:0]  cnt;
    logic                           cnt_sat;

    // Branch taken only when the control unit asks and the ALU compare is zero.
    assign o_mux = i_zero_alu & i_control_unit;

    assign inc[0] = i_control_unit;
    assign inc[1] = o_mux;

    genvar g;
    generate
        for (g = 0; g < NUM_CNT; g++) begin : g_cnt
            and_gate_satcnt #(.CNT_W(CNT_W)) u_cnt (
                .i_clk     (i_clk),
                .i_rst_n   (i_rst_n),
                .i_clr     (i_clr),
                .i_inc     (inc[g]),
                .o_cnt     (cnt[g]),
                .o_sat_hit (sat_hit[g])
            );
        end
    endgenerate

    assign vld_pipe[0] = o_mux;

    // One-cycle delayed copy of the select; clear does not touch it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            vld_pipe[STAGES:1] <= '0;
        else
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    // Sticky saturation flag, dropped only by reset or clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cnt_sat <= 1'b0;
        else if (i_clr)
            cnt_sat <= 1'b0;
        else if (|sat_hit)
            cnt_sat <= 1'b1;
    end

    assign o_mux_q      = vld_pipe[STAGES];
    assign o_branch_cnt = cnt[0];
    assign o_taken_cnt  = cnt[1];
    assign o_cnt_sat    = cnt_sat;
endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: a default-width instance and a CNT_W=2
// instance share all inputs so saturation is reachable in a few clocks.
module tb_and_gate;
    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst_n, a, b, clr;
    logic        mux, mux_q, sat;
    logic [15:0] bcnt, tcnt;
    logic        mux2, mux_q2, sat2;
    logic [1:0]  bcnt2, tcnt2;
    int          total = 0;
    int          bad = 0;

    always #5 if (clk_en) clk = ~clk;

    and_gate dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_zero_alu(a), .i_control_unit(b),
        .i_clr(clr), .o_mux(mux), .o_mux_q(mux_q), .o_branch_cnt(bcnt),
        .o_taken_cnt(tcnt), .o_cnt_sat(sat)
    );

    and_gate #(.CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_zero_alu(a), .i_control_unit(b),
        .i_clr(clr), .o_mux(mux2), .o_mux_q(mux_q2), .o_branch_cnt(bcnt2),
        .o_taken_cnt(tcnt2), .o_cnt_sat(sat2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on falling edges; check 1 time unit after that.
    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input int eq, input int et, input int es, input int eqq);
        chk({tag, " mux_q"}, {31'd0, mux_q}, eqq[31:0]);
        chk({tag, " bcnt"}, {16'd0, bcnt}, eq[31:0]);
        chk({tag, " tcnt"}, {16'd0, tcnt}, et[31:0]);
        chk({tag, " sat"}, {31'd0, sat}, es[31:0]);
    endtask

    task automatic chk_small(input string tag, input int eb, input int et, input int es);
        chk({tag, " bcnt2"}, {30'd0, bcnt2}, eb[31:0]);
        chk({tag, " tcnt2"}, {30'd0, tcnt2}, et[31:0]);
        chk({tag, " sat2"}, {31'd0, sat2}, es[31:0]);
    endtask

    initial begin
        rst_n = 1'b0; a = 1'b0; b = 1'b0; clr = 1'b0;
        #1;
        chk_main("reset", 0, 0, 0, 0);
        chk_small("reset", 0, 0, 0);

        // Truth table with no clock running (and reset held).
        a = 0; b = 0; #10; chk("tt 00", {31'd0, mux}, 0);
        a = 1; b = 0; #10; chk("tt 10", {31'd0, mux}, 0);
        a = 0; b = 1; #10; chk("tt 01", {31'd0, mux}, 0);
        a = 1; b = 1; #1;  chk("tt 11 zero-latency", {31'd0, mux}, 1);
        chk("tt 11 w2", {31'd0, mux2}, 1);
        #9;
        chk_main("reset held, clock off", 0, 0, 0, 0);

        // Start clock, release reset on a falling edge.
        a = 0; b = 0;
        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_main("after release", 0, 0, 0, 0);

        // a=b=1 for 5 clocks.
        a = 1; b = 1;
        clocks(1);
        chk_main("taken 1", 1, 1, 0, 1);
        clocks(4);
        chk_main("taken 5", 5, 5, 0, 1);
        chk_small("taken 5", 3, 3, 1);

        // b=1, a=0 for 3 clocks.
        a = 0;
        clocks(3);
        chk_main("not taken 3", 8, 5, 0, 0);
        chk_small("not taken 3", 3, 3, 1);

        // Clear with increments requested: clear wins, mux_q still follows.
        clr = 1; a = 1; b = 1;
        clocks(1);
        chk_main("clr priority", 0, 0, 0, 1);
        chk_small("clr priority", 0, 0, 0);
        clr = 0;

        // Narrow counter saturation boundary.
        clocks(3);
        chk_small("at max no sat", 3, 3, 0);
        clocks(1);
        chk_small("sat set", 3, 3, 1);
        clocks(2);
        chk_small("sat held", 3, 3, 1);
        chk_main("wide 6", 6, 6, 0, 1);

        clr = 1; a = 0;
        clocks(1);
        chk_small("clr sat", 0, 0, 0);
        chk_main("clr wide", 0, 0, 0, 0);
        clr = 0;

        // Build nonzero state, then drop reset mid-cycle.
        a = 1; b = 1;
        clocks(2);
        chk_main("pre-reset", 2, 2, 0, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_main("async reset", 0, 0, 0, 0);
        chk_small("async reset", 0, 0, 0);
        chk("mux in reset 11", {31'd0, mux}, 1);
        b = 0; #1;
        chk("mux in reset 10", {31'd0, mux}, 0);

        // Recovery: first update on the next rising edge after release.
        @(negedge clk);
        rst_n = 1'b1; b = 1;
        #1;
        chk_main("recover idle", 0, 0, 0, 0);
        clocks(1);
        chk_main("recover 1", 1, 1, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #100000;
        $display("FAIL timeout: sim did not finish, got running expected done");
        $fatal(1, "timeout");
    end
endmodule
